// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from an upstream FIFO and sends them as 8N1 serial frames.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic        fifo_wr,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_rd,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_cnt
);
  typedef enum logic [2:0] {IDLE, RD, LATCH, START, DATA, STOP} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_baud, w_baud, r_cnt;
  logic [2:0]  r_bit, w_bit;
  logic [7:0]  r_shift, w_shift;
  logic        r_tx, w_tx, w_last;
  assign w_last    = r_baud == 16'(CLKS_PER_BIT - 1);
  assign fifo_rd   = r_state == RD;
  assign busy      = r_state != IDLE;
  assign done      = r_state == STOP && w_last;
  assign tx        = r_tx;
  assign frame_cnt = r_cnt;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (en && !fifo_empty) ? RD : IDLE;
      RD:      w_next = fifo_wr ? IDLE : LATCH;
      LATCH:   w_next = START;
      START:   w_next = w_last ? DATA : START;
      DATA:    w_next = (w_last && r_bit == 3'd7) ? STOP : DATA;
      STOP:    w_next = w_last ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
    w_baud  = (w_next == r_state && !w_last && r_state inside {START, DATA, STOP}) ? r_baud + 16'd1 : '0;
    w_bit   = r_state != DATA ? '0 : r_bit + 3'(w_last);
    w_shift = r_state == LATCH ? fifo_dout : (r_state == DATA && w_last) ? {1'b0, r_shift[7:1]} : r_shift;
    // tx is registered from the next state so line and FSM change on the same edge
    w_tx    = w_next == START ? 1'b0 : w_next == DATA ? w_shift[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_baud  <= w_baud;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_tx    <= w_tx;
      if (done) r_cnt <= r_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of fifo_uart_tx against a small bench-side FIFO model.
module tb_fifo_uart_tx;
  logic        clk = 0, rst = 1, en = 0, fifo_wr = 0;
  logic [7:0]  fifo_dout = 0;
  logic        fifo_empty, fifo_rd, tx, busy, done;
  logic [15:0] frame_cnt;
  logic [7:0]  mem [16];
  logic [4:0]  wp = 0, rp = 0;
  int          cyc = 0, n_rd = 0, n_done = 0, n_chk = 0, n_fail = 0;
  int          t0, t1, t2, rd0, dn0;

  fifo_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_wr(fifo_wr),
    .fifo_dout(fifo_dout), .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .done(done),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  assign fifo_empty = wp == rp;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd) n_rd <= n_rd + 1;
    if (done) n_done <= n_done + 1;
    if (fifo_rd && !fifo_wr && wp != rp) begin
      fifo_dout <= mem[rp[3:0]];
      rp <= rp + 5'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp[3:0]] = b;
    wp = wp + 5'd1;
  endtask

  task automatic wait_start(output int ts);
    int n = 0;
    while (tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    ts = cyc;
    chk("start_seen", {63'b0, tx}, 64'h0);
  endtask

  task automatic recv(input string tag, input logic [7:0] b, output int ts);
    logic [39:0] s, d, e;
    wait_start(ts);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      s[k] = tx;
      d[k] = done;
      e[k] = (k < 4) ? 1'b0 : (k >= 36) ? 1'b1 : b[3'(k / 4 - 1)];
    end
    chk({tag, "_tx"}, 64'(s), 64'(e));
    chk({tag, "_done"}, 64'(d), 64'h80_0000_0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", 64'(tx), 64'h1);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_rd", 64'(fifo_rd), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_cnt", 64'(frame_cnt), 64'h0);
    rst = 0;
    // single byte 0xA5
    rd0 = n_rd; dn0 = n_done;
    push(8'hA5); en = 1;
    recv("a5", 8'hA5, t0);
    @(negedge clk);
    chk("a5_rd", 64'(n_rd - rd0), 64'h1);
    chk("a5_ndone", 64'(n_done - dn0), 64'h1);
    chk("a5_cnt", 64'(frame_cnt), 64'h1);
    chk("a5_idle", 64'(busy), 64'h0);
    // three back-to-back bytes
    rst = 1; @(negedge clk); rst = 0;
    rd0 = n_rd;
    push(8'h01); push(8'hFF); push(8'h00);
    recv("b01", 8'h01, t0);
    recv("bff", 8'hFF, t1);
    recv("b00", 8'h00, t2);
    @(negedge clk);
    chk("gap1", 64'(t1 - t0), 64'd43);
    chk("gap2", 64'(t2 - t1), 64'd43);
    chk("b3_rd", 64'(n_rd - rd0), 64'd3);
    chk("b3_cnt", 64'(frame_cnt), 64'd3);
    // write collides with the read strobe
    en = 0; rd0 = n_rd;
    push(8'h3C);
    @(negedge clk); en = 1;
    @(negedge clk);
    chk("wr_rd1", 64'(fifo_rd), 64'h1);
    fifo_wr = 1; push(8'h5A);
    @(negedge clk); fifo_wr = 0;
    chk("wr_back_idle", 64'(busy), 64'h0);
    @(negedge clk);
    chk("wr_rd2", 64'(fifo_rd), 64'h1);
    recv("w3c", 8'h3C, t0);
    recv("w5a", 8'h5A, t1);
    @(negedge clk);
    chk("wr_rd_total", 64'(n_rd - rd0), 64'd3);
    chk("wr_cnt", 64'(frame_cnt), 64'd5);
    // en low: no fetch; en dropped mid-frame: frame finishes, no further fetch
    en = 0; rd0 = n_rd; dn0 = n_done;
    push(8'h77); push(8'h88);
    repeat (20) @(negedge clk);
    chk("en0_rd", 64'(n_rd - rd0), 64'h0);
    chk("en0_tx", 64'(tx), 64'h1);
    chk("en0_busy", 64'(busy), 64'h0);
    en = 1;
    repeat (10) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'h1);
    en = 0;
    repeat (60) @(negedge clk);
    chk("mid_rd", 64'(n_rd - rd0), 64'h1);
    chk("mid_ndone", 64'(n_done - dn0), 64'h1);
    chk("mid_idle", 64'(busy), 64'h0);
    chk("mid_tx", 64'(tx), 64'h1);
    chk("mid_left", 64'(fifo_empty), 64'h0);
    en = 1;
    recv("m88", 8'h88, t0);
    @(negedge clk);
    chk("m_cnt", 64'(frame_cnt), 64'd7);
    // reset during data bit 3
    dn0 = n_done;
    push(8'hC3);
    wait_start(t0);
    repeat (17) @(negedge clk);
    chk("r_bit3", 64'(tx), 64'h0);
    rst = 1;
    @(negedge clk);
    chk("r_tx", 64'(tx), 64'h1);
    chk("r_busy", 64'(busy), 64'h0);
    chk("r_cnt", 64'(frame_cnt), 64'h0);
    chk("r_done", 64'(done), 64'h0);
    rst = 0;
    push(8'h96);
    recv("r96", 8'h96, t0);
    @(negedge clk);
    chk("r_ndone", 64'(n_done - dn0), 64'h1);
    chk("r_cnt1", 64'(frame_cnt), 64'h1);
    // frame counter wrap
    force dut.r_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_cnt;
    @(negedge clk);
    chk("wrap_pre", 64'(frame_cnt), 64'hFFFF);
    push(8'h42);
    recv("w42", 8'h42, t0);
    @(negedge clk);
    chk("wrap_cnt", 64'(frame_cnt), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit; legal values 2..65535.
REQ-002 clk  input  1  clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset rst, synchronous, active-high.
REQ-004 en  input  1  drain enable; a new byte is fetched only while en=1.
REQ-005 fifo_empty  input  1  empty flag of the upstream 16x8 FIFO.
REQ-006 fifo_wr  input  1  write strobe presented to the upstream FIFO in the same cycle; a read coincident with a write is ignored by the FIFO.
REQ-007 fifo_dout  input  8  FIFO read data, valid the cycle after an accepted read.
REQ-008 fifo_rd  output  1  read strobe to the FIFO.
REQ-009 tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 done  output  1  one-cycle pulse at the end of each stop bit.
REQ-012 frame_cnt  output  16  count of completed frames, wraps 0xFFFF->0x0000.

Function
REQ-013 FSM states SHALL be IDLE, RD, LATCH, START, DATA, STOP.
REQ-014 IDLE->RD when en=1 and fifo_empty=0; otherwise stay in IDLE.
REQ-015 fifo_rd SHALL be 1 exactly in cycles where state=RD, 0 otherwise.
REQ-016 RD->LATCH if fifo_wr=0 in the RD cycle; RD->IDLE if fifo_wr=1 (read dropped, retried from IDLE, no byte lost or duplicated).
REQ-017 In LATCH the shift register SHALL load fifo_dout at the closing edge; LATCH->START unconditionally.
REQ-018 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: bits 0..7 of the latched byte, LSB first, each held CLKS_PER_BIT cycles; 3-bit bit index, then STOP.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE; done=1 in the last STOP cycle; frame_cnt increments on the same edge.
REQ-021 tx SHALL be 1 in IDLE, RD and LATCH.
REQ-022 tx, state and bit index SHALL update on the same edge (registered output, no glitches).
REQ-023 Baud counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every state change.
REQ-024 Frame length SHALL be 10*CLKS_PER_BIT cycles; byte-to-byte period with data continuously available SHALL be 10*CLKS_PER_BIT+3 cycles.
REQ-025 en deasserted mid-frame SHALL NOT abort the frame; the next fetch is suppressed.
REQ-026 fifo_empty and fifo_wr SHALL be ignored in all states except IDLE and RD respectively.

Reset
REQ-027 While rst=1 at an edge: state=IDLE, fifo_rd=0, tx=1, busy=0, done=0, frame_cnt=0, baud counter and bit index=0.
REQ-028 rst mid-frame SHALL take effect on the next edge; the byte in flight is discarded, no done pulse, no count increment.
REQ-029 rst SHALL have priority over all other inputs.

Verification
REQ-030 CLKS_PER_BIT=4, FIFO holds 0xA5, en=1 -> one fifo_rd pulse; tx = 0,1,0,1,0,0,1,0,1,1 each for 4 cycles; done once; frame_cnt=1.
REQ-031 FIFO holds 0x01,0xFF,0x00 -> three frames, 43-cycle start-to-start spacing, three fifo_rd pulses, frame_cnt=3.
REQ-032 fifo_wr=1 in the RD cycle -> return to IDLE, second fifo_rd 1 cycle later, byte transmitted exactly once.
REQ-033 en=0 with fifo_empty=0 -> fifo_rd never asserted, tx=1, busy=0; en low mid-frame -> frame completes, no further fetch.
REQ-034 rst pulsed during DATA bit 3 -> next cycle tx=1, busy=0, frame_cnt=0, no done; after rst release with en=1 the next byte is sent intact.
REQ-035 Preload frame_cnt=0xFFFF via 65535 frames (or force) -> next completed frame gives 0x0000.
